// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-bank write-back queue.
package wb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back FIFO: storage, pointers and occupancy; exposes all entries for forwarding.
// Optional WB_COALESCE_EN: a push matching the tail address (count>=2) overwrites the tail data.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic [PW-1:0] rd_ptr,
  output logic [AW-1:0] ent_addr [DEPTH],
  output logic [DW-1:0] ent_data [DEPTH]
);

  logic [PW-1:0] wr_ptr;
  logic          coalesce;
  logic          push_new;

`ifdef WB_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - PW'(1);
  // Tail is never the popping head here since count>=2.
  assign coalesce = push && (count >= CW'(2)) && (ent_addr[tail_ptr] == push_addr);
`else
  assign coalesce = 1'b0;
`endif

  assign push_new  = push & ~coalesce;
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (push_new) begin
        ent_addr[wr_ptr] <= push_addr;
        ent_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
`ifdef WB_COALESCE_EN
      if (coalesce) ent_data[tail_ptr] <= push_data;
`endif
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_new && !pop)      count <= count + CW'(1);
      else if (!push_new && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back initiator for the 32x64 register bank: queued writes, drain, forwarding, flush.
// Optional macro WB_COALESCE_EN (handled in wb_fifo) merges back-to-back same-address writes.
//
// state | meaning
// IDLE  | accepting writes, draining when the bank is free
// FLUSH | writes blocked, draining until empty
// DONE  | one-cycle flush_done pulse
module reg_wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          drain_en,
  output logic [AW-1:0] Rw,
  output logic          WE_Reg,
  output logic [DW-1:0] dIN,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  input  logic [DW-1:0] doutA,
  input  logic [DW-1:0] doutB,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic          flush_req,
  output logic          flush_done,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  wb_state_t     state, state_nxt;
  logic          idle;
  logic          accept;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fwd_idx;
  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];

  assign wr_ready = idle && (count < CW'(DEPTH));
  assign accept   = wr_valid & wr_ready;
  // x0 writes complete the handshake but never occupy an entry.
  assign push     = accept && (wr_addr != '0);
  assign pop      = drain_en && (count != '0);

  assign WE_Reg = pop;
  assign Rw     = pop ? head_addr : '0;
  assign dIN    = pop ? head_data : '0;

  wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_addr(wr_addr),
    .push_data(wr_data),
    .pop      (pop),
    .head_addr(head_addr),
    .head_data(head_data),
    .count    (count),
    .rd_ptr   (rd_ptr),
    .ent_addr (ent_addr),
    .ent_data (ent_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush_req) state_nxt = FLUSH;
      FLUSH:   if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idle       = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE:    idle = 1'b1;
      DONE:    flush_done = 1'b1;
      default: ;
    endcase
  end

  // Walk oldest to youngest so the last match (newest value) wins.
  always_comb begin
    rdata_a = doutA;
    rdata_b = doutB;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if ((Ra != '0) && (ent_addr[fwd_idx] == Ra)) rdata_a = ent_data[fwd_idx];
        if ((Rb != '0) && (ent_addr[fwd_idx] == Rb)) rdata_b = ent_data[fwd_idx];
      end
    end
  end

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-back initiator for the 32x64 register bank, driving the bank's Rw/WE_Reg/dIN write port.
- Accepts write requests from the execute/load path over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drains one entry per cycle into the bank whenever the bank is available.
- Forwards pending (not yet written) data onto both read ports, so readers always see the newest value; supports a flush with completion pulse.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 5, register address width.
- DW, 64, data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  queue can accept
- wr_addr  in  AW  destination register
- wr_data  in  DW  write data
- drain_en  in  1  bank write port available this cycle
- Rw  out  AW  bank write address
- WE_Reg  out  1  bank write enable
- dIN  out  DW  bank write data
- Ra  in  AW  read address A (also routed to bank)
- Rb  in  AW  read address B (also routed to bank)
- doutA  in  DW  bank read data A
- doutB  in  DW  bank read data B
- rdata_a  out  DW  forwarded read data A
- rdata_b  out  DW  forwarded read data B
- flush_req  in  1  drain everything, then report done
- flush_done  out  1  one-cycle completion pulse
- count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO empty, count=0, state IDLE, WE_Reg=0, Rw=0, dIN=0, flush_done=0. Pointers and count cleared.
- Accept: a push occurs on a rising edge with wr_valid & wr_ready. wr_ready = (count<DEPTH) & (state==IDLE), from registered state only. Full with a same-cycle pop: push is not accepted (no pass-through).
- Register 0: accepted writes with wr_addr==0 complete the handshake but are discarded (no entry).
- Drain: WE_Reg = drain_en & (count!=0). Rw/dIN show the head entry when WE_Reg=1 and are 0 otherwise (combinational). The head pops on the same edge the bank samples the write.
- Latency: an accepted write reaches the bank at the earliest one cycle after acceptance.
- Push and pop in the same cycle: count is unchanged.
- Pointers wrap modulo DEPTH.
- Forwarding (combinational): rdata_a = data of the youngest valid entry whose addr==Ra, else doutA; same for B.
  - Ra==0 always returns doutA.
  - The head being written this cycle still forwards.
  - An entry being pushed this cycle does not forward (visible next cycle).
- FSM:
  - IDLE: flush_req=1 goes to FLUSH.
  - FLUSH: wr_ready=0; drain continues; when count==0 go to DONE.
  - DONE: flush_done=1 for exactly one cycle, then IDLE.
  - flush_req while in FLUSH/DONE is ignored.
  - flush_req with an empty queue: IDLE -> FLUSH -> DONE, so the pulse comes 2 cycles after the request.
- drain_en=0 holds all entries indefinitely; a flush waits.
- Reset mid-flush or mid-drain: all pending entries are lost; WE_Reg drops immediately (async).

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a push whose addr equals the tail entry's addr, with count>=2, overwrites the tail's data in place. count is unchanged and wr_ready is unaffected by this case.
- Undefined: every accepted non-zero write occupies its own entry. Forwarding is identical in both builds.

Decomposition:
- Shared package wb_pkg: AW/DW defaults, state enum {IDLE, FLUSH, DONE}, typedef wb_entry_t {addr[AW], data[DW]}.
- One natural sub-module: wb_fifo (storage, pointers, count, push/pop), with the top holding the FSM, the x0 filter and the forwarding priority mux.

Test Plan:
- Reset, drain_en=1, push (7,12) -> next cycle WE_Reg=1, Rw=7, dIN=12; the following cycle count=0, WE_Reg=0.
- drain_en=0, push (1,5), (2,6), (1,9), (3,3) -> count=4, wr_ready=0; Ra=1 gives rdata_a=9, Rb=2 gives rdata_b=6; a fifth push is not accepted.
- Full queue, drain_en=1 with wr_valid held -> one pop per cycle in FIFO order 1,2,1,3. When the full queue drains, the held write is accepted the following cycle; Ra=5 (not pending) returns doutA.
- Push (0,99) -> handshake completes, count stays 0, WE_Reg never asserts; Ra=0 returns doutA.
- Three entries pending, flush_req pulse, drain_en=1 -> wr_ready=0, three writes, flush_done high one cycle, then IDLE with wr_ready=1. Empty-queue flush -> pulse 2 cycles after the request.
- rst_n low mid-flush with 2 entries -> WE_Reg=0 immediately, count=0, flush_done never pulses. With WB_COALESCE_EN: push (4,1), (6,2), (6,8) with drain_en=0 -> count=2, and the entry for 6 holds 8.
